pim_mvm_seq: RTL
================

# pim_mvm_seq

Sequenced matrix-vector engine for the ReRAM PIM fabric. It time-multiplexes one shared crossbar macro across an arbitrarily wide input vector and a sweep of consecutive crossbar columns. The engine slices the input into ROW_TILE-wide tiles and issues them one per cycle. It accumulates the signed ADC results with selectable saturation and returns one result per column over a valid/ready handshake. It replaces the fully unrolled tile tree when area matters more than latency.

## Interface
Parameters:
- INPUT_SIZE, 96: input vector width; must be a multiple of ROW_TILE.
- ROW_TILE, 32: crossbar rows per access; T = INPUT_SIZE/ROW_TILE tiles.
- DEPTH, 5: column address width.
- ADC_P, 6: crossbar ADC output width, signed two's complement.
- ACC_W, 8: accumulator/output width; must be ≥ ADC_P.
- SAT, 1: 1 = saturate accumulation, 0 = wrap modulo 2^ACC_W.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  high only in IDLE.
- in_feature  in  INPUT_SIZE  input vector, latched on accept.
- in_addr  in  DEPTH  first column address.
- in_ncol  in  DEPTH  columns to sweep minus one (0 → 1 column).
- xb_en  out  1  crossbar access strobe.
- xb_data  out  ROW_TILE  current tile slice.
- xb_addr  out  DEPTH  current column address.
- xb_out  in  ADC_P  crossbar result, valid the cycle after xb_en.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_data  out  ACC_W  accumulated column result, signed.
- out_col  out  DEPTH  column address of out_data.
- out_last  out  1  final column of the sweep.
- out_sat  out  1  saturation/overflow occurred in this column.
- busy  out  1  state ≠ IDLE.

## Operation
- States are IDLE, ISSUE, DRAIN and OUT.
- IDLE: in_ready=1. Accept occurs when in_valid&&in_ready at a rising edge. On accept, latch in_feature, set col=in_addr, set remaining=in_ncol, clear acc, clear the sat flag, and go to ISSUE.
- ISSUE: hold xb_en=1 for T consecutive cycles with tile index k=0..T-1.
  - xb_data is in_feature[k*ROW_TILE +: ROW_TILE]; tile 0 is the LSB slice.
  - xb_addr is col.
  - After k=T-1, go to DRAIN.
- Accumulate on every cycle following an xb_en cycle: acc ← acc + sext(xb_out).
  - With SAT=1, clamp to [−2^(ACC_W−1), 2^(ACC_W−1)−1] and set sat on clamp.
  - With SAT=0, wrap and set sat on signed overflow.
  - Each step saturates; there is no end-of-sum correction.
- DRAIN: xb_en=0. The last result accumulates. Go to OUT.
- OUT: out_valid=1; out_data=acc, out_col=col, out_sat=sat, out_last=(remaining==0).
  - On out_valid&&out_ready, if remaining==0, go to IDLE.
  - Otherwise col←col+1 (wraps modulo 2^DEPTH), remaining−1, clear acc and sat, and go to ISSUE.
- Backpressure: while out_valid&&!out_ready, all out_* signals are held stable and xb_en stays 0.
- in_valid during busy is ignored; the request is not queued.
- xb_out is ignored on any cycle not following xb_en.
- Reset, including mid-sweep, has these effects on the next edge:
  - state=IDLE.
  - in_ready=1.
  - acc=0.
  - All other outputs are 0.
  - The in-flight sweep is discarded and no partial out_valid is produced.

## Timing
- Accept at edge E0 gives:
  - ISSUE in cycles 1..T.
  - DRAIN in cycle T+1.
  - out_valid in cycle T+2. With T=3, out_valid rises in cycle 5.
- Per column: T+2 cycles plus consumer stall cycles. Next column's first xb_en is the cycle after the out handshake.
- in_ready reasserts the cycle after the final out handshake. Back-to-back sweeps are separated by ≥1 IDLE cycle.
- Reset values: in_ready=1. xb_en, xb_data, xb_addr, out_valid, out_data, out_col, out_last, out_sat and busy are all 0.
- Crossbar read latency is fixed at exactly 1 cycle.

## Test plan
Defaults for all scenarios: INPUT_SIZE=96, ROW_TILE=32, ADC_P=6, ACC_W=8, DEPTH=5.
- Single column: in_addr=7, in_ncol=0, model returns 5, −3, 10.
  - xb_en in cycles 1–3 with xb_addr=7 and correct slices.
  - out_valid in cycle 5 with out_data=12, out_col=7, out_last=1, out_sat=0.
- Saturation: ACC_W=6; model returns 31, 31, 31.
  - SAT=1 gives out_data=31, out_sat=1.
  - SAT=0 gives out_data=29, out_sat=1.
  - Negative case: SAT=1 with −32, −32, 0 gives −32, sat=1.
- Sweep with wrap: in_addr=30, in_ncol=3.
  - Outputs have out_col 30, 31, 0, 1.
  - out_last is set only on col 1.
  - in_ready=1 the cycle after the 4th handshake.
- Backpressure: hold out_ready=0 for 5 cycles during OUT.
  - out_data and out_col are stable.
  - xb_en=0.
  - The next column's ISSUE starts the cycle after out_ready=1.
- Reset mid-sweep: assert rst in the ISSUE cycle of the 2nd column.
  - All outputs are 0 and in_ready=1 next cycle.
  - A fresh request afterwards yields a correct result with no stale acc.
- Busy-ignore: pulse in_valid with a different in_addr while busy.
  - No effect on the current sweep.
  - in_ready stays 0.

Source files
------------

// File: rtl/pim_mvm_seq.sv
// pim_mvm_seq: sequenced matrix-vector engine over one shared crossbar.
// Slices the input into ROW_TILE tiles, sweeps columns, accumulates ADC
// results (saturating or wrapping) and returns one result per column.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   request handshake (ready only in IDLE)
//   in_feature          input vector, latched on accept
//   in_addr, in_ncol    first column, column count minus one
//   xb_en/xb_data/      crossbar strobe, tile slice, column address
//   xb_addr, xb_out     xb_out is valid the cycle after xb_en
//   out_valid/out_ready result handshake
//   out_data, out_col   signed column result and its column address
//   out_last, out_sat   final column flag, saturation/overflow flag
//   busy                engine not idle
module pim_mvm_seq #(
    parameter int INPUT_SIZE = 96,
    parameter int ROW_TILE   = 32,
    parameter int DEPTH      = 5,
    parameter int ADC_P      = 6,
    parameter int ACC_W      = 8,
    parameter int SAT        = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INPUT_SIZE-1:0] in_feature,
    input  logic [DEPTH-1:0]      in_addr,
    input  logic [DEPTH-1:0]      in_ncol,
    output logic                  xb_en,
    output logic [ROW_TILE-1:0]   xb_data,
    output logic [DEPTH-1:0]      xb_addr,
    input  logic [ADC_P-1:0]      xb_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      out_data,
    output logic [DEPTH-1:0]      out_col,
    output logic                  out_last,
    output logic                  out_sat,
    output logic                  busy
);

    localparam int T  = INPUT_SIZE / ROW_TILE;
    localparam int KW = (T > 1) ? $clog2(T) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(T - 1);

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        OUT
    } state_t;

    state_t                  state;
    logic [INPUT_SIZE-1:0]   feat;
    logic [KW-1:0]           k;
    logic [KW-1:0]           k_nx;
    logic [DEPTH-1:0]        col;
    logic [DEPTH-1:0]        remaining;
    logic [ACC_W-1:0]        acc;
    logic                    sat;
    // High in the cycle after an xb_en cycle: xb_out carries a result.
    logic                    acc_en;

    logic [ACC_W:0]          sum;
    logic                    ovf;
    logic [ACC_W-1:0]        acc_nx;
    logic                    sat_nx;
    logic [ACC_W-1:0]        acc_upd;
    logic                    sat_upd;

    assign k_nx = k + KW'(1);

    // One guard bit above the accumulator exposes signed overflow.
    assign sum = {acc[ACC_W-1], acc}
               + {{(ACC_W+1-ADC_P){xb_out[ADC_P-1]}}, xb_out};
    assign ovf = sum[ACC_W] ^ sum[ACC_W-1];

    always_comb begin
        acc_nx = sum[ACC_W-1:0];
        sat_nx = sat | ovf;
        if (SAT != 0 && ovf) begin
            acc_nx = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    assign acc_upd = acc_en ? acc_nx : acc;
    assign sat_upd = acc_en ? sat_nx : sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            xb_en     <= 1'b0;
            xb_data   <= '0;
            xb_addr   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_col   <= '0;
            out_last  <= 1'b0;
            out_sat   <= 1'b0;
            feat      <= '0;
            k         <= '0;
            col       <= '0;
            remaining <= '0;
            acc       <= '0;
            sat       <= 1'b0;
            acc_en    <= 1'b0;
        end else begin
            acc_en <= xb_en;
            if (acc_en) begin
                acc <= acc_nx;
                sat <= sat_nx;
            end
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        feat      <= in_feature;
                        col       <= in_addr;
                        remaining <= in_ncol;
                        acc       <= '0;
                        sat       <= 1'b0;
                        k         <= '0;
                        xb_en     <= 1'b1;
                        xb_data   <= in_feature[ROW_TILE-1:0];
                        xb_addr   <= in_addr;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (k == K_LAST) begin
                        xb_en <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        k       <= k_nx;
                        xb_data <= feat[int'(k_nx)*ROW_TILE +: ROW_TILE];
                    end
                end
                DRAIN: begin
                    // Final tile result lands this cycle; publish it directly.
                    out_valid <= 1'b1;
                    out_data  <= acc_upd;
                    out_sat   <= sat_upd;
                    out_col   <= col;
                    out_last  <= (remaining == '0);
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (remaining == '0) begin
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            col       <= col + DEPTH'(1);
                            remaining <= remaining - DEPTH'(1);
                            acc       <= '0;
                            sat       <= 1'b0;
                            k         <= '0;
                            xb_en     <= 1'b1;
                            xb_data   <= feat[ROW_TILE-1:0];
                            xb_addr   <= col + DEPTH'(1);
                            state     <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
